vga_fb_sched: RTL and testbench
===============================

# vga_fb_sched

Write-port scheduler for the VGA frame buffer (`vga_frame`). It arbitrates a single pixel write path between the CPU store port and an internal fill engine. The fill engine clears or paints whole colour planes with a constant word. Registered outputs drive `i_pxlAddr` / `i_pxlData` / `i_ctrlVGA` of `vga_frame` in the `i_clk` domain. Exactly one write, or a no-op, is issued per cycle.

## Interface
- `X_LAST`, 8'd252: last X byte address written by the fill.
- `X_STEP`, 8'd4: X increment per fill word; must divide `X_LAST`.
- `Y_LAST`, 8'd239: last row written by the fill.
- `i_clk`  in  1  system clock. One clock for the whole block.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_cpu_req`  in  1  CPU write request; held until acked.
- `i_cpu_addr`  in  32  CPU pixel address: [17:16] plane, [15:8] Y, [7:0] X.
- `i_cpu_data`  in  32  CPU write data.
- `i_cpu_ctrl`  in  `mem_ctrl_t`  CPU memory control, passed through unchanged.
- `o_cpu_ack`  out  1  combinational grant; the write appears on the outputs the next cycle.
- `i_fill_start`  in  1  one-cycle start pulse.
- `i_fill_plane`  in  2  plane select: 0 = red, 1 = green, 2 = blue, 3 = all three in order.
- `i_fill_data`  in  32  fill word, latched at start.
- `i_fill_ctrl`  in  `mem_ctrl_t`  word-store control used for fill writes, latched at start.
- `i_fill_abort`  in  1  abort the fill.
- `o_fill_busy`  out  1  fill in progress.
- `o_fill_done`  out  1  one-cycle pulse on completion.
- `o_pxlAddr`  out  32  to `vga_frame`.
- `o_pxlData`  out  32  to `vga_frame`.
- `o_ctrlVGA`  out  `mem_ctrl_t`  to `vga_frame`; `'0` is a no-op.

## Operation
- **States:** `S_IDLE` and `S_FILL`.
- **`S_IDLE` behaviour:**
  - CPU is granted whenever `i_cpu_req` = 1.
  - `i_fill_start` latches plane, data and ctrl, clears X/Y, and moves to `S_FILL`.
  - For plane 3, the plane counter starts at 0.
- **`S_FILL` write sequence:**
  - Each fill grant writes `{14'b0, plane, Y, X}`.
  - X steps by `X_STEP`; at `X_LAST` it wraps to 0 and Y increments.
  - At `Y_LAST` / `X_LAST` the plane is complete.
  - In mode 3, the plane counter advances 0→1→2; otherwise the fill is done.
  - The last grant returns the FSM to `S_IDLE`.
- **Arbitration in `S_FILL`** (see Configuration):
  - If only one side requests, that side is granted.
  - On conflict, grant alternates using a last-grant flag. The flag resets to "fill", so the CPU wins the first conflict.
- **Start and abort rules:**
  - `i_fill_start` while busy is ignored.
  - `i_fill_abort` in `S_FILL` returns to `S_IDLE` next edge with no done pulse. A CPU grant in that same cycle is still honoured.
  - Abort in `S_IDLE` has no effect.
  - Start and abort in the same `S_IDLE` cycle: start wins.
- **Output register:** captures the granted source's addr/data/ctrl. With no grant it loads addr = 0, data = 0, ctrl = `'0`.
- **CPU address:** passed through unchanged, including plane 3, which `vga_frame` drops.
- **Fill length:** a single plane takes `(Y_LAST+1)*(X_LAST/X_STEP+1)` fill writes; mode 3 takes three times that.

## Timing
- **Reset values:** FSM = `S_IDLE`, counters = 0, last-grant = fill. Outputs: `o_pxlAddr` = 0, `o_pxlData` = 0, `o_ctrlVGA` = `'0`, `o_fill_busy` = 0, `o_fill_done` = 0.
- **Reset mid-fill:** the fill is lost and no done pulse is produced.
- **CPU handshake:**
  - `o_cpu_ack` is high in cycle N iff `i_cpu_req` = 1 and the CPU is granted in N; it is low during reset.
  - Write latency is 1: the granted write appears on the outputs in N+1.
  - A CPU holding `i_cpu_req` high gets back-to-back writes while it keeps winning.
- **Busy:** `o_fill_busy` rises the cycle after start is accepted. It falls the cycle after the final fill grant, i.e. the cycle the final write is on the outputs.
- **Done:** `o_fill_done` pulses in that same cycle.
- **Throughput:** with no CPU traffic, fill runs at one word per cycle.

## Configuration
- **`VGA_FB_SCHED_RR_EN` defined:** round-robin on conflict as above. This bounds CPU wait to 1 cycle and fill stall to 1 cycle per CPU write.
- **`VGA_FB_SCHED_RR_EN` undefined:** strict CPU priority. Fill is granted only when `i_cpu_req` = 0, and the last-grant flag is removed.

## Test plan
Bench parameters: `X_LAST` = 8, `X_STEP` = 4, `Y_LAST` = 1 (6 words per plane).
- **Plane fill:** start, plane 1, data `32'hFFFF_FFFF`, no CPU traffic → 6 consecutive writes at addr `0x10000`, `0x10004`, `0x10008`, `0x10100`, `0x10104`, `0x10108`. `o_fill_done` pulses with the last write; busy is high for exactly 6 cycles.
- **All planes:** start, plane 3 → 18 writes covering planes 0, 1, 2 in order, then one done pulse.
- **Contention, RR on:** CPU holds req (addr `0x20505`) for 4 cycles during a fill → acks alternate CPU/fill/CPU/fill; the fill completes 4 cycles later than uncontended.
- **Contention, RR off:** same stimulus → 4 CPU writes, then the fill resumes at the next address.
- **Abort:** abort after the 3rd fill write → no 4th write, busy drops next cycle, no done pulse. A new start then restarts at X = 0, Y = 0.
- **Reset and idle CPU:** async reset asserted mid-fill → outputs 0 and ack 0 immediately. After release, a CPU req in `S_IDLE` is acked the same cycle and its write appears on the next cycle.

Source files
------------

// File: rtl/vga_fb_sched.sv
// Purpose: schedules the single pixel write path into vga_frame, arbitrating CPU stores against a plane fill engine.
// Latency: a write granted in cycle N (o_cpu_ack, or an internal fill grant) is on o_pxlAddr/o_pxlData/o_ctrlVGA in N+1.
// Backpressure: the CPU holds i_cpu_req until o_cpu_ack; the fill engine stalls in place whenever it loses arbitration.
//
// Ports:
//   i_clk, i_rst_n                       clock, asynchronous active-low reset
//   i_cpu_req/addr/data/ctrl, o_cpu_ack  CPU store port; addr = {plane[17:16], Y[15:8], X[7:0]}
//   i_fill_start/plane/data/ctrl         fill launch (plane 3 = red, green, blue in sequence)
//   i_fill_abort                         cancel a running fill, with no done pulse
//   o_fill_busy, o_fill_done             fill status; done pulses with the final write on the outputs
//   o_pxlAddr/o_pxlData/o_ctrlVGA        registered write to vga_frame; o_ctrlVGA == '0 is a no-op
// The ctrl fields carry vga_frame's mem_ctrl_t flattened to CTRL_W bits.
// Build option: define VGA_FB_SCHED_RR_EN to alternate grants on conflict. Without it the CPU has strict priority.
module vga_fb_sched #(
  parameter logic [7:0]  X_LAST = 8'd252,
  parameter logic [7:0]  X_STEP = 8'd4,
  parameter logic [7:0]  Y_LAST = 8'd239,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic [31:0]       i_cpu_addr,
  input  logic [31:0]       i_cpu_data,
  input  logic [CTRL_W-1:0] i_cpu_ctrl,
  output logic              o_cpu_ack,
  input  logic              i_fill_start,
  input  logic [1:0]        i_fill_plane,
  input  logic [31:0]       i_fill_data,
  input  logic [CTRL_W-1:0] i_fill_ctrl,
  input  logic              i_fill_abort,
  output logic              o_fill_busy,
  output logic              o_fill_done,
  output logic [31:0]       o_pxlAddr,
  output logic [31:0]       o_pxlData,
  output logic [CTRL_W-1:0] o_ctrlVGA
);

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_e;

  state_e            state_q;
  logic [1:0]        plane_q;
  logic              mode3_q;
  logic [7:0]        x_q;
  logic [7:0]        y_q;
  logic [31:0]       fill_data_q;
  logic [CTRL_W-1:0] fill_ctrl_q;
  logic              done_q;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
`ifdef VGA_FB_SCHED_RR_EN
  logic              last_fill_q;  // 1: the fill engine took the most recent grant
`endif

  logic fill_req, cpu_gnt, fill_gnt;
  logic x_end, plane_end, fill_end;

  // An abort withdraws the fill request in the same cycle, so no further fill word is issued.
  assign fill_req = (state_q == S_FILL) && !i_fill_abort;

`ifdef VGA_FB_SCHED_RR_EN
  // On conflict the side that did not take the last grant wins.
  assign cpu_gnt = i_cpu_req && (!fill_req || last_fill_q);
`else
  assign cpu_gnt = i_cpu_req;
`endif
  assign fill_gnt = fill_req && !cpu_gnt;

  // The grant is combinational, so it is masked while reset is held.
  assign o_cpu_ack = cpu_gnt && i_rst_n;

  assign x_end     = (x_q == X_LAST);
  assign plane_end = x_end && (y_q == Y_LAST);
  assign fill_end  = plane_end && (!mode3_q || (plane_q == 2'd2));

  always_comb begin
    addr_d = '0;
    data_d = '0;
    ctrl_d = '0;
    if (cpu_gnt) begin
      addr_d = i_cpu_addr;
      data_d = i_cpu_data;
      ctrl_d = i_cpu_ctrl;
    end else if (fill_gnt) begin
      addr_d = {14'b0, plane_q, y_q, x_q};
      data_d = fill_data_q;
      ctrl_d = fill_ctrl_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      plane_q     <= 2'd0;
      mode3_q     <= 1'b0;
      x_q         <= 8'd0;
      y_q         <= 8'd0;
      fill_data_q <= '0;
      fill_ctrl_q <= '0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      ctrl_q      <= '0;
`ifdef VGA_FB_SCHED_RR_EN
      last_fill_q <= 1'b1;
`endif
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      done_q <= 1'b0;
`ifdef VGA_FB_SCHED_RR_EN
      if (cpu_gnt) begin
        last_fill_q <= 1'b0;
      end else if (fill_gnt) begin
        last_fill_q <= 1'b1;
      end
`endif
      case (state_q)
        S_IDLE: begin
          // A start is accepted even if abort is also high this cycle.
          if (i_fill_start) begin
            plane_q     <= (i_fill_plane == 2'd3) ? 2'd0 : i_fill_plane;
            mode3_q     <= (i_fill_plane == 2'd3);
            fill_data_q <= i_fill_data;
            fill_ctrl_q <= i_fill_ctrl;
            x_q         <= 8'd0;
            y_q         <= 8'd0;
            state_q     <= S_FILL;
          end
        end
        S_FILL: begin
          if (i_fill_abort) begin
            state_q <= S_IDLE;
          end else if (fill_gnt) begin
            if (fill_end) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else if (plane_end) begin
              x_q     <= 8'd0;
              y_q     <= 8'd0;
              plane_q <= plane_q + 2'd1;
            end else if (x_end) begin
              x_q <= 8'd0;
              y_q <= y_q + 8'd1;
            end else begin
              x_q <= x_q + X_STEP;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_fill_busy = (state_q == S_FILL);
  assign o_fill_done = done_q;
  assign o_pxlAddr   = addr_q;
  assign o_pxlData   = data_q;
  assign o_ctrlVGA   = ctrl_q;

endmodule

// File: tb/tb_vga_fb_sched.sv
// Purpose: self-checking bench for vga_fb_sched with a small 3x2-word plane geometry.
// Latency: expects granted writes one cycle after the grant; done with the last write.
// Backpressure: CPU driver holds req until ack; expected write order is queued up front.
module tb_vga_fb_sched;

  localparam logic [3:0] FCTRL = 4'hC;
  localparam logic [3:0] CCTRL = 4'h3;
  localparam int         WPP   = 6;
  // {Y, X} of each fill word within one plane, in issue order.
  localparam logic [15:0] XY [WPP] = '{16'h0000, 16'h0004, 16'h0008, 16'h0100, 16'h0104, 16'h0108};
`ifdef VGA_FB_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  c;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cpu_req;
  logic [31:0] i_cpu_addr;
  logic [31:0] i_cpu_data;
  logic [3:0]  i_cpu_ctrl;
  logic        o_cpu_ack;
  logic        i_fill_start;
  logic [1:0]  i_fill_plane;
  logic [31:0] i_fill_data;
  logic [3:0]  i_fill_ctrl;
  logic        i_fill_abort;
  logic        o_fill_busy;
  logic        o_fill_done;
  logic [31:0] o_pxlAddr;
  logic [31:0] o_pxlData;
  logic [3:0]  o_ctrlVGA;

  vga_fb_sched #(
    .X_LAST(8'd8), .X_STEP(8'd4), .Y_LAST(8'd1), .CTRL_W(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(i_cpu_req), .i_cpu_addr(i_cpu_addr), .i_cpu_data(i_cpu_data),
    .i_cpu_ctrl(i_cpu_ctrl), .o_cpu_ack(o_cpu_ack),
    .i_fill_start(i_fill_start), .i_fill_plane(i_fill_plane), .i_fill_data(i_fill_data),
    .i_fill_ctrl(i_fill_ctrl), .i_fill_abort(i_fill_abort),
    .o_fill_busy(o_fill_busy), .o_fill_done(o_fill_done),
    .o_pxlAddr(o_pxlAddr), .o_pxlData(o_pxlData), .o_ctrlVGA(o_ctrlVGA)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int  checks;
  int  failures;
  wr_t exp_q [$];
  int  busy_cnt;
  int  done_cnt;
  int  done_cyc;
  int  start_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic wr_t fill_wr(input logic [1:0] pl, input int idx, input logic [31:0] d);
    wr_t w;
    w.a = {14'b0, pl, XY[idx]};
    w.d = d;
    w.c = FCTRL;
    return w;
  endfunction

  function automatic wr_t cpu_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    w.c = CCTRL;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard/monitor: every non-no-op write must match the head of exp_q.
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_fill_busy) busy_cnt++;
        if (o_fill_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (o_ctrlVGA != 4'h0) begin
          if (exp_q.size() == 0) begin
            check("sb_extra_wr", {28'h0, o_ctrlVGA}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check("sb_addr", o_pxlAddr, e.a);
            check("sb_data", o_pxlData, e.d);
            check("sb_ctrl", {28'h0, o_ctrlVGA}, {28'h0, e.c});
          end
        end
      end
    end
  endtask

  task automatic fill_start(input logic [1:0] pl, input logic [31:0] d, input logic ab);
    tick();
    i_fill_start = 1'b1;
    i_fill_plane = pl;
    i_fill_data  = d;
    i_fill_ctrl  = FCTRL;
    i_fill_abort = ab;
    start_cyc    = cyc;
    tick();
    i_fill_start = 1'b0;
    i_fill_abort = 1'b0;
    i_fill_data  = 32'h0;
    i_fill_ctrl  = 4'h0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (o_fill_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'h0, o_fill_busy}, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  // Called just after a rising edge; returns just after the edge that follows the ack.
  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, output int waited);
    i_cpu_req  = 1'b1;
    i_cpu_addr = a;
    i_cpu_data = d;
    i_cpu_ctrl = CCTRL;
    waited     = 0;
    @(negedge clk);
    while (!o_cpu_ack && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    tick();
    i_cpu_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0, w;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    i_cpu_req = 1'b1;
    i_cpu_addr = 32'h0001_0203;
    i_cpu_data = 32'h1234_5678;
    i_cpu_ctrl = CCTRL;
    i_fill_start = 1'b0;
    i_fill_plane = 2'd0;
    i_fill_data = 32'h0;
    i_fill_ctrl = 4'h0;
    i_fill_abort = 1'b0;

    // Reset state, with a CPU request held that must not be acked.
    #12;
    check("rst_ack", {31'h0, o_cpu_ack}, 32'h0);
    check("rst_addr", o_pxlAddr, 32'h0);
    check("rst_data", o_pxlData, 32'h0);
    check("rst_ctrl", {28'h0, o_ctrlVGA}, 32'h0);
    check("rst_busy", {31'h0, o_fill_busy}, 32'h0);
    check("rst_done", {31'h0, o_fill_done}, 32'h0);
    i_cpu_req = 1'b0;
    #11 rst_n = 1'b1;
    fork
      monitor();
    join_none
    @(negedge clk);
    check("post_rst_addr", o_pxlAddr, 32'h0);
    check("post_rst_busy", {31'h0, o_fill_busy}, 32'h0);

    // Single plane fill, with a second start while busy that must be ignored.
    b0 = busy_cnt;
    d0 = done_cnt;
    for (int i = 0; i < WPP; i++) exp_q.push_back(fill_wr(2'd1, i, 32'hFFFF_FFFF));
    fill_start(2'd1, 32'hFFFF_FFFF, 1'b0);
    tick();
    i_fill_start = 1'b1;
    i_fill_plane = 2'd2;
    tick();
    i_fill_start = 1'b0;
    wait_idle("p1_timeout");
    check("p1_done_cnt", done_cnt - d0, 1);
    check("p1_busy_cyc", busy_cnt - b0, WPP);
    check("p1_done_lat", done_cyc - start_cyc, WPP + 1);
    check("p1_sb_left", exp_q.size(), 0);

    // All three planes in order.
    b0 = busy_cnt;
    d0 = done_cnt;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < WPP; i++) exp_q.push_back(fill_wr(p[1:0], i, 32'hA5A5_0F0F));
    fill_start(2'd3, 32'hA5A5_0F0F, 1'b0);
    wait_idle("all_timeout");
    check("all_done_cnt", done_cnt - d0, 1);
    check("all_busy_cyc", busy_cnt - b0, 3 * WPP);
    check("all_done_lat", done_cyc - start_cyc, 3 * WPP + 1);
    check("all_sb_left", exp_q.size(), 0);

    // Contention: 4 CPU writes arrive after two fill words have been granted.
    b0 = busy_cnt;
    d0 = done_cnt;
    exp_q.push_back(fill_wr(2'd0, 0, 32'h1357_9BDF));
    exp_q.push_back(fill_wr(2'd0, 1, 32'h1357_9BDF));
`ifdef VGA_FB_SCHED_RR_EN
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(cpu_wr(32'h0002_0505, 32'hC000_0000 + 32'(i)));
      exp_q.push_back(fill_wr(2'd0, 2 + i, 32'h1357_9BDF));
    end
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(cpu_wr(32'h0002_0505, 32'hC000_0000 + 32'(i)));
    for (int i = 2; i < WPP; i++) exp_q.push_back(fill_wr(2'd0, i, 32'h1357_9BDF));
`endif
    fill_start(2'd0, 32'h1357_9BDF, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      cpu_write(32'h0002_0505, 32'hC000_0000 + 32'(i), w);
      check("cont_cpu_wait", w, (RR && i > 0) ? 1 : 0);
    end
    wait_idle("cont_timeout");
    check("cont_done_cnt", done_cnt - d0, 1);
    check("cont_done_lat", done_cyc - start_cyc, WPP + 1 + 4);
    check("cont_busy_cyc", busy_cnt - b0, WPP + 4);
    check("cont_sb_left", exp_q.size(), 0);

    // Abort while the 3rd fill word is on the outputs.
    b0 = busy_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back(fill_wr(2'd0, i, 32'h5555_AAAA));
    fill_start(2'd0, 32'h5555_AAAA, 1'b0);
    tick();
    tick();
    tick();
    i_fill_abort = 1'b1;
    tick();
    i_fill_abort = 1'b0;
    @(negedge clk);
    check("abort_busy_low", {31'h0, o_fill_busy}, 32'h0);
    repeat (3) @(negedge clk);
    check("abort_done_cnt", done_cnt - d0, 0);
    check("abort_busy_cyc", busy_cnt - b0, 4);
    check("abort_sb_left", exp_q.size(), 0);

    // Restart from X=0/Y=0, with abort raised in the same idle cycle as start.
    d0 = done_cnt;
    for (int i = 0; i < WPP; i++) exp_q.push_back(fill_wr(2'd2, i, 32'h0F0F_F0F0));
    fill_start(2'd2, 32'h0F0F_F0F0, 1'b1);
    wait_idle("restart_timeout");
    check("restart_done_cnt", done_cnt - d0, 1);
    check("restart_sb_left", exp_q.size(), 0);

    // Asynchronous reset mid-fill, then a CPU write from idle.
    d0 = done_cnt;
    for (int i = 0; i < WPP; i++) exp_q.push_back(fill_wr(2'd1, i, 32'h1111_2222));
    fill_start(2'd1, 32'h1111_2222, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", o_pxlAddr, 32'h0);
    check("arst_data", o_pxlData, 32'h0);
    check("arst_ctrl", {28'h0, o_ctrlVGA}, 32'h0);
    check("arst_busy", {31'h0, o_fill_busy}, 32'h0);
    check("arst_done", {31'h0, o_fill_done}, 32'h0);
    i_cpu_req  = 1'b1;
    i_cpu_addr = 32'h0003_0102;
    i_cpu_data = 32'hCAFE_F00D;
    i_cpu_ctrl = CCTRL;
    #1;
    check("arst_ack", {31'h0, o_cpu_ack}, 32'h0);
    check("arst_sb_left", exp_q.size(), WPP - 1);
    exp_q.delete();
    exp_q.push_back(cpu_wr(32'h0003_0102, 32'hCAFE_F00D));
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("idle_ack", {31'h0, o_cpu_ack}, 32'h1);
    tick();
    i_cpu_req = 1'b0;
    @(negedge clk);
    check("idle_wr_addr", o_pxlAddr, 32'h0003_0102);
    check("idle_wr_data", o_pxlData, 32'hCAFE_F00D);
    repeat (3) @(negedge clk);
    check("arst_no_done", done_cnt - d0, 0);
    check("arst_idle_busy", {31'h0, o_fill_busy}, 32'h0);
    check("final_sb_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
